// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the pc_sequencer fetch-stage block.
package pc_seq_pkg;

    localparam int unsigned DEFAULT_D         = 12;
    localparam int unsigned DEFAULT_START_PC  = 0;
    localparam int unsigned DEFAULT_RAS_DEPTH = 4;
    localparam int unsigned LUT_IDX_W         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/table/imem-facing signal bundle of pc_sequencer; the slave modport is
// the sequencer side, the master modport is the decoder/table/environment side.
interface pc_sequencer_if #(
    parameter int D = 12
);
    import pc_seq_pkg::*;

    logic                 start;
    logic                 halt_req;
    logic                 stall;
    logic                 br_en;
    logic                 br_cond;
    logic [LUT_IDX_W-1:0] br_idx;
    logic                 call_en;
    logic                 ret_en;
    logic [LUT_IDX_W-1:0] lut_addr;
    logic [D-1:0]         lut_target;
    logic [D-1:0]         pc;
    logic                 fetch_valid;
    logic                 done;
    logic                 ras_err;

    modport master (
        output start, halt_req, stall, br_en, br_cond, br_idx, call_en, ret_en,
        output lut_target,
        input  lut_addr, pc, fetch_valid, done, ras_err
    );

    modport slave (
        input  start, halt_req, stall, br_en, br_cond, br_idx, call_en, ret_en,
        input  lut_target,
        output lut_addr, pc, fetch_valid, done, ras_err
    );

endinterface

// File: rtl/ras_stack.sv
// Return-address stack as a circular buffer; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [D-1:0] push_data_i,
    output logic [D-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [D-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, top_idx;
    logic [CW-1:0] count_q, count_d;
    logic          do_write;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign top_idx  = ptr_dec(wr_ptr_q);
    assign top_o    = mem_q[top_idx];
    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_write = push_i && !pop_i && !clear_i;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (pop_i && !empty_o) begin
            wr_ptr_d = top_idx;
            count_d  = count_q - 1'b1;
        end else if (do_write) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            if (!full_o) count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q gates every read, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: start/halt control, stalls, branches, calls/returns.
// Define PC_SEQ_RAS_EN to build in the return-address stack; otherwise call is a plain jump.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D         = DEFAULT_D,
    parameter int START_PC  = DEFAULT_START_PC,
    parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic           clk,
    input  logic           reset_n,
    pc_sequencer_if.slave  bus
);
    seq_state_e   state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [D-1:0] pc_plus1;

    assign pc_plus1         = pc_q + D'(1);
    assign bus.lut_addr     = bus.br_idx;
    assign bus.pc           = pc_q;
    assign bus.done         = (state_q == HALT);
    assign bus.fetch_valid  = (state_q == RUN) && !bus.stall;

`ifdef PC_SEQ_RAS_EN
    logic         ras_err_q, ras_err_d;
    logic         stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    logic [D-1:0] stk_top;

    ras_stack #(.D(D), .DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (stk_clear),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (pc_plus1),
        .top_o       (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    assign bus.ras_err = ras_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ras_err_q <= 1'b0;
        else          ras_err_q <= ras_err_d;
    end
`else
    assign bus.ras_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_SEQ_RAS_EN
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        ras_err_d = ras_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = D'(START_PC);
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (bus.ret_en) begin
`ifdef PC_SEQ_RAS_EN
                        if (stk_empty) begin
                            pc_d      = pc_plus1;
                            ras_err_d = 1'b1;
                        end else begin
                            pc_d    = stk_top;
                            stk_pop = 1'b1;
                        end
`else
                        pc_d = pc_plus1;
`endif
                    end else if (bus.call_en) begin
`ifdef PC_SEQ_RAS_EN
                        stk_push = 1'b1;
                        if (stk_full) ras_err_d = 1'b1;
`endif
                        pc_d = bus.lut_target;
                    end else if (bus.br_en && bus.br_cond) begin
                        pc_d = bus.lut_target;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = D'(START_PC);
`ifdef PC_SEQ_RAS_EN
                    stk_clear = 1'b1;
                    ras_err_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= D'(START_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: rule-level model compared every cycle, plus directed literals.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int D         = 12;
    localparam int START_PC  = 0;
    localparam int RAS_DEPTH = 4;
    localparam int MASK      = (1 << D) - 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pc_sequencer_if #(.D(D)) bus ();

    pc_sequencer #(.D(D), .START_PC(START_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Branch-target table: index 2 -> 503, index 3 -> 328, everything else -> 0.
    function automatic int tgt(input logic [7:0] idx);
        case (idx)
            8'd2:    return 503;
            8'd3:    return 328;
            default: return 0;
        endcase
    endfunction

    always_comb bus.lut_target = D'(tgt(bus.lut_addr));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, pc and a queue of return addresses (newest at back).
    typedef enum {M_IDLE, M_RUN, M_HALT} mode_e;
    mode_e m_mode;
    int    m_pc;
    int    m_stack[$];
    bit    m_err;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = START_PC;
        m_stack.delete();
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        if (!reset_n) return;
        case (m_mode)
            M_IDLE: if (bus.start) begin m_mode = M_RUN; m_pc = START_PC; end
            M_HALT: if (bus.start) begin
                m_mode = M_RUN; m_pc = START_PC; m_stack.delete(); m_err = 1'b0;
            end
            M_RUN: if (!bus.stall) begin
                if (bus.halt_req) m_mode = M_HALT;
                else if (bus.ret_en) begin
`ifdef PC_SEQ_RAS_EN
                    if (m_stack.size() == 0) begin m_pc = (m_pc + 1) & MASK; m_err = 1'b1; end
                    else m_pc = m_stack.pop_back();
`else
                    m_pc = (m_pc + 1) & MASK;
`endif
                end else if (bus.call_en) begin
`ifdef PC_SEQ_RAS_EN
                    if (m_stack.size() == RAS_DEPTH) begin m_stack.delete(0); m_err = 1'b1; end
                    m_stack.push_back((m_pc + 1) & MASK);
`endif
                    m_pc = tgt(bus.br_idx);
                end else if (bus.br_en && bus.br_cond) m_pc = tgt(bus.br_idx);
                else m_pc = (m_pc + 1) & MASK;
            end
            default: ;
        endcase
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_pc", 32'(bus.pc), 32'(m_pc));
        check("cyc_done", 32'(bus.done), 32'(m_mode == M_HALT));
        check("cyc_fetch_valid", 32'(bus.fetch_valid), 32'(m_mode == M_RUN && !bus.stall));
        check("cyc_ras_err", 32'(bus.ras_err), 32'(m_err));
        check("cyc_lut_addr", 32'(bus.lut_addr), 32'(bus.br_idx));
    end

    task automatic drive(input logic s, h, st, be, bc, input logic [7:0] idx, input logic ce, re);
        bus.start = s;  bus.halt_req = h; bus.stall = st; bus.br_en = be;
        bus.br_cond = bc; bus.br_idx = idx; bus.call_en = ce; bus.ret_en = re;
    endtask

    task automatic cyc(input logic s, h, st, be, bc, input logic [7:0] idx, input logic ce, re);
        drive(s, h, st, be, bc, idx, ce, re);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'd0, 0, 0);
    endtask

    task automatic restart_to(input int n);
        cyc(0, 1, 0, 0, 0, 8'd0, 0, 0);
        cyc(1, 0, 0, 0, 0, 8'd0, 0, 0);
        idle(n);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 8'd0, 0, 0);
        model_reset();
        #2;
        check("reset_pc", 32'(bus.pc), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("reset_ras_err", 32'(bus.ras_err), 32'd0);
        reset_n = 1'b1;

        cyc(1, 0, 0, 0, 0, 8'd0, 0, 0);
        check("start_pc", 32'(bus.pc), 32'd0);
        check("start_fetch_valid", 32'(bus.fetch_valid), 32'd1);
        idle(3);
        check("seq_pc3", 32'(bus.pc), 32'd3);
        check("seq_done", 32'(bus.done), 32'd0);

        idle(2);
        cyc(0, 0, 0, 1, 1, 8'd2, 0, 0);
        check("br_taken", 32'(bus.pc), 32'd503);
        restart_to(5);
        cyc(0, 0, 0, 1, 0, 8'd2, 0, 0);
        check("br_not_taken", 32'(bus.pc), 32'd6);

        restart_to(10);
        cyc(0, 0, 0, 0, 0, 8'd3, 1, 0);
        check("call_pc", 32'(bus.pc), 32'd328);
        cyc(0, 0, 0, 0, 0, 8'd0, 0, 1);
`ifdef PC_SEQ_RAS_EN
        check("ret_pc", 32'(bus.pc), 32'd11);
`else
        check("ret_pc", 32'(bus.pc), 32'd329);
`endif
        check("ret_ras_err", 32'(bus.ras_err), 32'd0);

        // Five nested calls alternating targets 328/503; return addresses 1,329,504,329,504.
        restart_to(0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, (i % 2 == 0) ? 8'd3 : 8'd2, 1, 0);
        check("nest_pc", 32'(bus.pc), 32'd328);
`ifdef PC_SEQ_RAS_EN
        check("nest_overflow_err", 32'(bus.ras_err), 32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 8'd0, 0, 1);
        check("nest_oldest_lost", 32'(bus.pc), 32'd329);
        cyc(0, 0, 0, 0, 0, 8'd0, 0, 1);
        check("underflow_pc", 32'(bus.pc), 32'd330);
`else
        check("nest_no_err", 32'(bus.ras_err), 32'd0);
`endif
        cyc(0, 0, 0, 0, 0, 8'd3, 1, 1);  // ret and call together: ret wins

        restart_to(7);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 1, 8'd2, 0, 0);
            check("stall_pc", 32'(bus.pc), 32'd7);
            check("stall_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        end
        cyc(0, 1, 0, 1, 1, 8'd2, 0, 0);
        check("halt_pc", 32'(bus.pc), 32'd7);
        check("halt_done", 32'(bus.done), 32'd1);
        cyc(0, 0, 0, 1, 1, 8'd2, 0, 0);
        check("halt_hold_pc", 32'(bus.pc), 32'd7);

        restart_to(4095);
        check("wrap_pre", 32'(bus.pc), 32'd4095);
        idle(1);
        check("wrap_post", 32'(bus.pc), 32'd0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 8'd0, 0, 0);
        check("start_ignored_in_run", 32'(bus.pc), 32'd3);

        // Asynchronous reset while stalled mid-RUN, no clock edge in between.
        drive(0, 0, 1, 0, 0, 8'd3, 1, 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_pc", 32'(bus.pc), 32'd0);
        check("async_rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        cyc(0, 0, 0, 0, 0, 8'd0, 0, 0);
        check("idle_after_rst", 32'(bus.fetch_valid), 32'd0);
        reset_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 8'd0, 0, 0);
        idle(1);
        check("resume_pc", 32'(bus.pc), 32'd1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
